// File: rtl/cc1200_rx_pkg.sv
// Shared types and constants for the CC1200 receive deframer.
package cc1200_rx_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        HEADER    = 3'd2,
        PAYLOAD   = 3'd3,
        DRAIN     = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        HDR_NONE   = 2'd0,
        HDR_VSYNC0 = 2'd1,
        HDR_VSYNC1 = 2'd2,
        HDR_HSYNC  = 2'd3
    } hdr_type_t;

    localparam int unsigned HDR_BITS = 48;
    localparam int unsigned PIX_BITS = 12;
    localparam int unsigned ADD_BITS = 16;
    localparam int unsigned SYNC_BITS = HDR_BITS - ADD_BITS;

    localparam logic [SYNC_BITS-1:0] SYNC_VSYNC0 = 32'h93AA_AADE;
    localparam logic [SYNC_BITS-1:0] SYNC_VSYNC1 = 32'h9355_55DE;
    localparam logic [SYNC_BITS-1:0] SYNC_HSYNC  = 32'h6CF4_AE21;

    // Map the sync field of a completed header to its type code.
    function automatic hdr_type_t hdr_classify(input logic [SYNC_BITS-1:0] sync);
        hdr_type_t t;
        t = HDR_NONE;
        if (sync == SYNC_VSYNC0) t = HDR_VSYNC0;
        else if (sync == SYNC_VSYNC1) t = HDR_VSYNC1;
        else if (sync == SYNC_HSYNC) t = HDR_HSYNC;
        return t;
    endfunction

endpackage

// File: rtl/rx_spi_sync.sv
// Synchronizers and edge detectors for the asynchronous SPI pins; all event outputs registered.
module rx_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic miso,
    input  logic cs_n,
    output logic sample,
    output logic start,
    output logic stop,
    output logic miso_s,
    output logic cs_level
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] miso_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic                   sclk_prev;
    logic                   cs_prev;

    // CS_n chain resets low so a burst already in progress looks active until CS_n is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr   <= '0;
            miso_sr   <= '0;
            cs_sr     <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
            sample    <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            miso_s    <= 1'b0;
            cs_level  <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            miso_sr   <= {miso_sr[SYNC_STAGES-2:0], miso};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
            cs_prev   <= cs_sr[SYNC_STAGES-1];
            sample    <= sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
            start     <= ~cs_sr[SYNC_STAGES-1] & cs_prev;
            stop      <= cs_sr[SYNC_STAGES-1] & ~cs_prev;
            miso_s    <= miso_sr[SYNC_STAGES-1];
            cs_level  <= cs_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/cc1200_rx_deframer.sv
// CC1200 SPI read-stream deframer: 48-bit header classification then 12-bit pixel words.
// Optional statistics counters are built when RX_DEFRAMER_STATS_EN is defined.
module cc1200_rx_deframer
    import cc1200_rx_pkg::*;
#(
    parameter int unsigned MAX_PIX     = 80,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                Cclk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                MISO,
    input  logic                CS_n,
    output logic [PIX_BITS-1:0] RxData,
    output logic                RxValid,
    output logic                RxHeader,
    output logic [ADD_BITS-1:0] RxAdd,
    output logic                RxAddValid,
    output logic [1:0]          RxHdrType,
    output logic [15:0]         ShortBurstCnt,
    output logic [15:0]         BadHdrCnt
);

    localparam int unsigned BCW = 6;
    localparam int unsigned PCW = $clog2(MAX_PIX + 1);

    logic sample, start, stop, miso_s, cs_level;

    rx_spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (Cclk),
        .rst      (rst),
        .sclk     (SCLK),
        .miso     (MISO),
        .cs_n     (CS_n),
        .sample   (sample),
        .start    (start),
        .stop     (stop),
        .miso_s   (miso_s),
        .cs_level (cs_level)
    );

    rx_state_t              state, state_next;
    logic [BCW-1:0]         bit_cnt;
    logic [PCW-1:0]         pix_cnt;
    logic [HDR_BITS-2:0]    hdr_sr;
    logic [PIX_BITS-2:0]    pix_sr;

    logic                   hdr_shift_c, pix_shift_c;
    logic                   hdr_done_c, pix_done_c, last_pix_c;
    logic [HDR_BITS-1:0]    hdr_next_c;
    logic [PIX_BITS-1:0]    pix_next_c;
    hdr_type_t              hdr_type_c;
    logic [BCW-1:0]         bits_after_c;

    always_ff @(posedge Cclk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    // A sample coinciding with stop is folded in first; stop then wins the transition.
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_IDLE: if (cs_level) state_next = IDLE;
            IDLE:      if (start) state_next = HEADER;
            HEADER: begin
                if (stop)            state_next = IDLE;
                else if (hdr_done_c) state_next = (hdr_type_c != HDR_NONE) ? PAYLOAD : DRAIN;
            end
            PAYLOAD: begin
                if (stop)            state_next = IDLE;
                else if (last_pix_c) state_next = DRAIN;
            end
            DRAIN:     if (stop) state_next = IDLE;
            default:   state_next = WAIT_IDLE;
        endcase
    end

    // Per-cycle datapath decisions derived from the current state and pin events.
    always_comb begin
        hdr_shift_c = (state == HEADER) && sample;
        pix_shift_c = (state == PAYLOAD) && sample;
        hdr_next_c  = {hdr_sr, miso_s};
        pix_next_c  = {pix_sr, miso_s};
        hdr_done_c  = hdr_shift_c && (bit_cnt == BCW'(HDR_BITS - 1));
        pix_done_c  = pix_shift_c && (bit_cnt == BCW'(PIX_BITS - 1));
        hdr_type_c  = hdr_classify(hdr_next_c[HDR_BITS-1:ADD_BITS]);
        last_pix_c  = pix_done_c && (pix_cnt == PCW'(MAX_PIX - 1));
        bits_after_c = bit_cnt;
        if (hdr_done_c || pix_done_c)       bits_after_c = '0;
        else if (hdr_shift_c || pix_shift_c) bits_after_c = bit_cnt + BCW'(1);
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            hdr_sr     <= '0;
            pix_sr     <= '0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            RxHeader   <= 1'b0;
            RxAdd      <= '0;
            RxAddValid <= 1'b0;
            RxHdrType  <= '0;
        end else begin
            RxValid    <= 1'b0;
            RxAddValid <= 1'b0;
            RxHeader   <= (state_next == HEADER);
            if (state == IDLE && start) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
            end else begin
                bit_cnt <= bits_after_c;
            end
            if (hdr_shift_c) hdr_sr <= hdr_next_c[HDR_BITS-2:0];
            if (pix_shift_c) pix_sr <= pix_next_c[PIX_BITS-2:0];
            if (hdr_done_c) begin
                RxHdrType <= 2'(hdr_type_c);
                if (hdr_type_c != HDR_NONE) begin
                    RxAdd      <= hdr_next_c[ADD_BITS-1:0];
                    RxAddValid <= 1'b1;
                end
            end
            if (pix_done_c) begin
                RxData  <= pix_next_c;
                RxValid <= 1'b1;
                pix_cnt <= pix_cnt + PCW'(1);
            end
        end
    end

`ifdef RX_DEFRAMER_STATS_EN
    logic short_c, bad_c;

    always_comb begin
        short_c = stop && (state == HEADER || state == PAYLOAD) && (bits_after_c != '0);
        bad_c   = hdr_done_c && (hdr_type_c == HDR_NONE);
    end

    // Saturating statistics counters.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            ShortBurstCnt <= '0;
            BadHdrCnt     <= '0;
        end else begin
            if (short_c && ShortBurstCnt != 16'hFFFF) ShortBurstCnt <= ShortBurstCnt + 16'd1;
            if (bad_c && BadHdrCnt != 16'hFFFF)       BadHdrCnt     <= BadHdrCnt + 16'd1;
        end
    end
`else
    assign ShortBurstCnt = '0;
    assign BadHdrCnt     = '0;
`endif

endmodule

// File: tb/tb_cc1200_rx_deframer.sv
// Directed bench for cc1200_rx_deframer: burst table plus reset, header-flag and sample/stop corner sequences.
module tb_cc1200_rx_deframer;

`ifdef RX_DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Cclk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        MISO = 1'b0;
    logic        CS_n = 1'b1;
    logic [11:0] RxData;
    logic        RxValid;
    logic        RxHeader;
    logic [15:0] RxAdd;
    logic        RxAddValid;
    logic [1:0]  RxHdrType;
    logic [15:0] ShortBurstCnt;
    logic [15:0] BadHdrCnt;

    cc1200_rx_deframer #(.MAX_PIX(4), .SYNC_STAGES(2)) dut (
        .Cclk(Cclk), .rst(rst), .SCLK(SCLK), .MISO(MISO), .CS_n(CS_n),
        .RxData(RxData), .RxValid(RxValid), .RxHeader(RxHeader),
        .RxAdd(RxAdd), .RxAddValid(RxAddValid), .RxHdrType(RxHdrType),
        .ShortBurstCnt(ShortBurstCnt), .BadHdrCnt(BadHdrCnt)
    );

    always #5 Cclk = ~Cclk;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int addv_cnt = 0;
    int width_err = 0;
    logic [11:0] data_q[$];
    logic prev_v = 1'b0;
    logic prev_a = 1'b0;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge Cclk) begin
        if (RxValid) begin
            valid_cnt++;
            data_q.push_back(RxData);
        end
        if (RxAddValid) addv_cnt++;
        if ((RxValid && prev_v) || (RxAddValid && prev_a) || (RxValid && RxAddValid)) width_err++;
        prev_v = RxValid;
        prev_a = RxAddValid;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        addv_cnt = 0;
        data_q.delete();
    endtask

    task automatic spi_bit(input logic b);
        MISO = b;
        repeat (4) @(negedge Cclk);
        SCLK = 1'b1;
        repeat (4) @(negedge Cclk);
        SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] hdr, input int hb, input int np,
                             input logic [71:0] pixw, input int extra);
        for (int i = 0; i < hb; i++) spi_bit(hdr[47-i]);
        for (int k = 0; k < np; k++)
            for (int b = 0; b < 12; b++) spi_bit(pixw[71-12*k-b]);
        for (int e = 0; e < extra; e++) spi_bit(1'((e % 3) == 0));
    endtask

    task automatic run_burst(input logic [47:0] hdr, input int hb, input int np,
                             input logic [71:0] pixw, input int extra);
        CS_n = 1'b0;
        repeat (6) @(negedge Cclk);
        send_bits(hdr, hb, np, pixw, extra);
        repeat (3) @(negedge Cclk);
        CS_n = 1'b1;
        repeat (12) @(negedge Cclk);
    endtask

    typedef struct {
        logic [47:0] hdr;
        int          hb;
        int          np;
        logic [71:0] pixw;
        int          extra;
        int          exp_valid;
        int          exp_addv;
        logic [1:0]  exp_type;
        logic [15:0] exp_add;
        int          bad_inc;
        int          short_inc;
    } vec_t;

    vec_t vecs[7];
    int   cum_short = 0;
    int   cum_bad = 0;

    task automatic check_stats(input string nm);
        chk({nm, "_short"}, 64'(ShortBurstCnt), STATS ? 64'(cum_short) : 64'd0);
        chk({nm, "_bad"},   64'(BadHdrCnt),     STATS ? 64'(cum_bad)   : 64'd0);
    endtask

    initial begin
        logic [71:0] pw;

        vecs[0] = '{48'h6CF4AE21_00A0, 48, 3, 72'hABC123FFF000000000, 0, 3, 1, 2'd3, 16'h00A0, 0, 0};
        vecs[1] = '{48'h935555DE_0000, 48, 0, 72'h0,                  0, 0, 1, 2'd2, 16'h0000, 0, 0};
        vecs[2] = '{48'h12345678_0050, 48, 0, 72'h0,                 24, 0, 0, 2'd0, 16'h0000, 1, 0};
        vecs[3] = '{48'h93AAAADE_1234, 48, 6, 72'h111222333444555666, 0, 4, 1, 2'd1, 16'h1234, 0, 0};
        vecs[4] = '{48'h6CF4AE21_0007, 48, 0, 72'h0,                  5, 0, 1, 2'd3, 16'h0007, 0, 1};
        vecs[5] = '{48'h6CF4AE21_00FF, 48, 1, 72'h5A5000000000000000, 0, 1, 1, 2'd3, 16'h00FF, 0, 0};
        vecs[6] = '{48'h93AAAADE_4321, 20, 0, 72'h0,                  0, 0, 0, 2'd3, 16'h00FF, 0, 1};

        repeat (5) @(negedge Cclk);
        rst = 1'b0;
        @(negedge Cclk);
        chk("rst_data",  64'(RxData), 64'd0);
        chk("rst_valid", 64'(RxValid), 64'd0);
        chk("rst_hdr",   64'(RxHeader), 64'd0);
        chk("rst_add",   64'(RxAdd), 64'd0);
        chk("rst_addv",  64'(RxAddValid), 64'd0);
        chk("rst_type",  64'(RxHdrType), 64'd0);
        check_stats("rst");
        repeat (10) @(negedge Cclk);

        for (int i = 0; i < 7; i++) begin
            clear_mon();
            run_burst(vecs[i].hdr, vecs[i].hb, vecs[i].np, vecs[i].pixw, vecs[i].extra);
            cum_short += vecs[i].short_inc;
            cum_bad   += vecs[i].bad_inc;
            chk($sformatf("v%0d_valid_cnt", i), 64'(valid_cnt), 64'(vecs[i].exp_valid));
            pw = vecs[i].pixw;
            for (int k = 0; k < vecs[i].exp_valid; k++)
                chk($sformatf("v%0d_data%0d", i, k), 64'(data_q[k]), 64'(pw[71-12*k -: 12]));
            chk($sformatf("v%0d_addv_cnt", i), 64'(addv_cnt), 64'(vecs[i].exp_addv));
            chk($sformatf("v%0d_type", i), 64'(RxHdrType), 64'(vecs[i].exp_type));
            chk($sformatf("v%0d_add", i), 64'(RxAdd), 64'(vecs[i].exp_add));
            chk($sformatf("v%0d_rxheader", i), 64'(RxHeader), 64'd0);
            check_stats($sformatf("v%0d", i));
        end

        // RxHeader is high during the header and low once the 48th bit lands.
        clear_mon();
        CS_n = 1'b0;
        repeat (6) @(negedge Cclk);
        send_bits(48'h12345678_0050, 10, 0, 72'h0, 0);
        chk("hflag_during", 64'(RxHeader), 64'd1);
        for (int i = 10; i < 48; i++) spi_bit(((48'h12345678_0050 >> (47 - i)) & 48'd1) != 48'd0);
        repeat (8) @(negedge Cclk);
        chk("hflag_after", 64'(RxHeader), 64'd0);
        send_bits(48'h0, 0, 0, 72'h0, 12);
        repeat (3) @(negedge Cclk);
        CS_n = 1'b1;
        repeat (12) @(negedge Cclk);
        cum_bad++;
        chk("hflag_strobes", 64'(valid_cnt + addv_cnt), 64'd0);
        check_stats("hflag");

        // Final pixel sample and CS_n rise detected in the same cycle.
        clear_mon();
        CS_n = 1'b0;
        repeat (6) @(negedge Cclk);
        send_bits(48'h6CF4AE21_0011, 48, 0, 72'h0, 0);
        for (int b = 0; b < 11; b++) spi_bit(((12'h3C9 >> (11 - b)) & 12'd1) != 12'd0);
        MISO = 1'b1;
        repeat (4) @(negedge Cclk);
        SCLK = 1'b1;
        CS_n = 1'b1;
        repeat (4) @(negedge Cclk);
        SCLK = 1'b0;
        repeat (12) @(negedge Cclk);
        chk("simul_valid_cnt", 64'(valid_cnt), 64'd1);
        chk("simul_data", 64'(data_q[0]), 64'h3C9);
        chk("simul_add", 64'(RxAdd), 64'h0011);
        check_stats("simul");

        // Reset mid-payload with CS_n held low; the in-flight burst must be rejected.
        clear_mon();
        CS_n = 1'b0;
        repeat (6) @(negedge Cclk);
        send_bits(48'h6CF4AE21_0022, 48, 1, 72'h111000000000000000, 5);
        rst = 1'b1;
        repeat (3) @(negedge Cclk);
        rst = 1'b0;
        cum_short = 0;
        cum_bad = 0;
        @(negedge Cclk);
        chk("mrst_data", 64'(RxData), 64'd0);
        chk("mrst_add", 64'(RxAdd), 64'd0);
        chk("mrst_type", 64'(RxHdrType), 64'd0);
        check_stats("mrst");
        clear_mon();
        send_bits(48'h6CF4AE21_0033, 20, 0, 72'h0, 0);
        repeat (6) @(negedge Cclk);
        chk("mrst_strobes", 64'(valid_cnt + addv_cnt), 64'd0);
        chk("mrst_rxheader", 64'(RxHeader), 64'd0);
        CS_n = 1'b1;
        repeat (12) @(negedge Cclk);
        clear_mon();
        run_burst(48'h93AAAADE_0BEE, 48, 2, 72'h0F000F000000000000, 0);
        chk("post_valid_cnt", 64'(valid_cnt), 64'd2);
        chk("post_data0", 64'(data_q[0]), 64'h0F0);
        chk("post_data1", 64'(data_q[1]), 64'h00F);
        chk("post_addv_cnt", 64'(addv_cnt), 64'd1);
        chk("post_add", 64'(RxAdd), 64'h0BEE);
        chk("post_type", 64'(RxHdrType), 64'd1);
        check_stats("post");

        chk("strobe_width", 64'(width_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
